seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode 7-segment display. It is
//  the parametrised successor to the single-digit hex decoder. Snapshots a packed
//  hex value, scans one digit per slot, and adds per-digit enable, decimal points,

---
 rtl/seg7_scan_driver_pkg.sv | 25 ++
 rtl/seg7_scan_driver_hex_decode.sv | 31 +++
 rtl/seg7_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment codes are active-low, bit0 = segment a.
package seg7_scan_driver_pkg;

    localparam int NUM_PHASES = 16;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h18;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex nibble to active-low 7-segment code.
// Shapes use lowercase b and d so they differ from 8 and 0.
module seg7_hex_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] code
);

    always_comb begin
        unique case (nib)
            4'h0: code = SEG_0;
            4'h1: code = SEG_1;
            4'h2: code = SEG_2;
            4'h3: code = SEG_3;
            4'h4: code = SEG_4;
            4'h5: code = SEG_5;
            4'h6: code = SEG_6;
            4'h7: code = SEG_7;
            4'h8: code = SEG_8;
            4'h9: code = SEG_9;
            4'hA: code = SEG_A;
            4'hB: code = SEG_B;
            4'hC: code = SEG_C;
            4'hD: code = SEG_D;
            4'hE: code = SEG_E;
            4'hF: code = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit time-multiplexed 7-segment driver with frame-aligned capture,
// per-digit enable, decimal points, leading-zero blanking and PWM dimming.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int PHASE_DIV   = 3125,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  blank_lz,
    input  logic [3:0]            brightness,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int DIV_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PHASE_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [3:0]       PH_LAST  = 4'(NUM_PHASES - 1);

    localparam logic [6:0]          SEG_IDLE = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic                DP_IDLE  = SEG_ACT_LOW;
    localparam logic [N_DIGITS-1:0] AN_IDLE  = AN_ACT_LOW ? '1 : '0;

    typedef struct packed {
        logic [4*N_DIGITS-1:0] val;
        logic [N_DIGITS-1:0]   dp;
        logic [N_DIGITS-1:0]   en;
    } disp_t;

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       phase;
    logic [IDX_W-1:0] idx;

    disp_t pend;
    disp_t shadow;
    disp_t incoming;
    logic  pend_vld;

    logic div_wrap;
    logic ph_wrap;
    logic frame_end;

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign ph_wrap   = div_wrap && (phase == PH_LAST);
    assign frame_end = ph_wrap && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            phase   <= '0;
            idx     <= '0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            phase   <= phase + 4'd1;
            if (ph_wrap)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign incoming = '{val: value, dp: dp_in, en: digit_en};

    // A load coinciding with the boundary bypasses pending so it is
    // visible in the frame that starts right now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            shadow   <= '0;
            pend_vld <= 1'b0;
        end else begin
            if (load)
                pend <= incoming;
            if (frame_end) begin
                pend_vld <= 1'b0;
                if (load)
                    shadow <= incoming;
                else if (pend_vld)
                    shadow <= pend;
            end else if (load) begin
                pend_vld <= 1'b1;
            end
        end
    end

    logic [N_DIGITS-1:0] lz;

    // Disabled digits count as zero so they do not stop blanking.
    always_comb begin
        logic run;
        lz  = '0;
        run = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            run   = run & ~|(shadow.val[4*i +: 4] & {4{shadow.en[i]}});
            lz[i] = run;
        end
    end

    logic [3:0] cur_nib;
    logic [6:0] cur_code;
    logic       lit;

    assign cur_nib = shadow.val[{idx, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nib  (cur_nib),
        .code (cur_code)
    );

    assign lit = (phase != 4'd0)
              && (phase <= brightness)
              && shadow.en[idx]
              && !(blank_lz && lz[idx]);

    logic [N_DIGITS-1:0] an_on;
    logic [6:0]          seg_al;
    logic                dp_on;

    always_comb begin
        an_on      = '0;
        an_on[idx] = lit;
    end

    assign seg_al = lit ? cur_code : SEG_OFF;
    assign dp_on  = lit && shadow.dp[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= AN_IDLE;
            seg        <= SEG_IDLE;
            dp         <= DP_IDLE;
            frame_done <= 1'b0;
        end else begin
            an         <= AN_ACT_LOW ? ~an_on : an_on;
            seg        <= SEG_ACT_LOW ? seg_al : ~seg_al;
            dp         <= SEG_ACT_LOW ? ~dp_on : dp_on;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, PHASE_DIV=2,
// active-low pins, so one slot is 32 clks and one frame 128 clks.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int vecs = 0;
    int errs = 0;

    logic [3:0] an_s  [384];
    logic [6:0] seg_s [384];
    logic       dp_s  [384];
    logic       fd_s  [384];

    localparam logic [27:0] C_12AF = {7'h79, 7'h24, 7'h08, 7'h0E};
    localparam logic [27:0] C_0050 = {7'h7F, 7'h7F, 7'h12, 7'h40};
    localparam logic [27:0] C_0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] C_3456 = {7'h30, 7'h19, 7'h12, 7'h02};
    localparam logic [27:0] C_0C0D = {7'h40, 7'h46, 7'h40, 7'h21};

    seg7_scan_driver #(
        .N_DIGITS    (4),
        .PHASE_DIV   (2),
        .SEG_ACT_LOW (1'b1),
        .AN_ACT_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Sample t reflects counter state t of the frame (t=0: digit 0, phase 0).
    function automatic logic [11:0] exp_word(
        input int          t,
        input logic [3:0]  lm,
        input logic [27:0] codes,
        input logic [3:0]  dps,
        input int          br
    );
        int   d;
        int   p;
        logic lit;
        d   = (t % 128) / 32;
        p   = (t % 32) / 2;
        lit = (p >= 1) && (p <= br) && lm[d];
        if (lit)
            return {4'hF ^ (4'h1 << d), codes[d*7 +: 7], ~dps[d]};
        return {4'hF, 7'h7F, 1'b1};
    endfunction

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic capture(
        input int          n,
        input bit          sync,
        input int          ld0,
        input logic [15:0] v0,
        input int          ld1,
        input logic [15:0] v1
    );
        int k;
        if (sync) begin
            k = 0;
            while (frame_done !== 1'b1 && k < 400) begin
                @(negedge clk);
                k++;
            end
            vecs++;
            if (k >= 400) begin
                errs++;
                $display("FAIL sync: frame_done=%b after %0d clks, want 1", frame_done, k);
            end
        end
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            an_s[t]  = an;
            seg_s[t] = seg;
            dp_s[t]  = dp;
            fd_s[t]  = frame_done;
            load = (t == ld0) || (t == ld1);
            if (t == ld0) value = v0;
            if (t == ld1) value = v1;
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        value      = 16'h0;
        dp_in      = 4'h0;
        digit_en   = 4'h0;
        blank_lz   = 1'b0;
        brightness = 4'd15;
        load       = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL reset_hold: got an=%b seg=%h dp=%b fd=%b, want 1111/7f/1/0", an, seg, dp, frame_done);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vecs++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL reset_empty: got an=%b seg=%h dp=%b fd=%b, want 1111/7f/1/0", an, seg, dp, frame_done);
        end
    endtask

    task automatic test_basic_scan();
        logic [11:0] got;
        logic [11:0] want;
        value    = 16'h12AF;
        digit_en = 4'hF;
        dp_in    = 4'h0;
        pulse_load();
        capture(128, 1'b1, -1, 16'h0, -1, 16'h0);
        for (int t = 0; t < 128; t++) begin
            got  = {an_s[t], seg_s[t], dp_s[t]};
            want = exp_word(t, 4'hF, C_12AF, 4'h0, 15);
            vecs++;
            if (got !== want) begin
                errs++;
                $display("FAIL basic t=%0d: got %h want %h", t, got, want);
            end
            vecs++;
            if (fd_s[t] !== (t == 127)) begin
                errs++;
                $display("FAIL basic_fd t=%0d: got %b want %b", t, fd_s[t], t == 127);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [11:0] got;
        logic [11:0] want;
        blank_lz = 1'b1;
        value    = 16'h0050;
        pulse_load();
        capture(128, 1'b1, -1, 16'h0, -1, 16'h0);
        for (int t = 0; t < 128; t++) begin
            got  = {an_s[t], seg_s[t], dp_s[t]};
            want = exp_word(t, 4'b0011, C_0050, 4'h0, 15);
            vecs++;
            if (got !== want) begin
                errs++;
                $display("FAIL lz_0050 t=%0d: got %h want %h", t, got, want);
            end
        end
        value = 16'h0000;
        pulse_load();
        capture(128, 1'b1, -1, 16'h0, -1, 16'h0);
        for (int t = 0; t < 128; t++) begin
            got  = {an_s[t], seg_s[t], dp_s[t]};
            want = exp_word(t, 4'b0001, C_0000, 4'h0, 15);
            vecs++;
            if (got !== want) begin
                errs++;
                $display("FAIL lz_0000 t=%0d: got %h want %h", t, got, want);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_brightness();
        logic [11:0] got;
        logic [11:0] want;
        int          n_lit;
        value      = 16'h12AF;
        brightness = 4'd4;
        pulse_load();
        capture(128, 1'b1, -1, 16'h0, -1, 16'h0);
        n_lit = 0;
        for (int t = 0; t < 128; t++) begin
            got  = {an_s[t], seg_s[t], dp_s[t]};
            want = exp_word(t, 4'hF, C_12AF, 4'h0, 4);
            vecs++;
            if (got !== want) begin
                errs++;
                $display("FAIL br4 t=%0d: got %h want %h", t, got, want);
            end
            if (t < 32 && an_s[t] !== 4'hF) n_lit++;
        end
        vecs++;
        if (n_lit !== 8) begin
            errs++;
            $display("FAIL br4_duty: got %0d lit clks in slot 0, want 8", n_lit);
        end
        brightness = 4'd0;
        capture(128, 1'b1, -1, 16'h0, -1, 16'h0);
        for (int t = 0; t < 128; t++) begin
            vecs++;
            if (an_s[t] !== 4'hF) begin
                errs++;
                $display("FAIL br0 t=%0d: got an=%b want 1111", t, an_s[t]);
            end
        end
        brightness = 4'd15;
    endtask

    task automatic test_load_timing();
        logic [11:0] got;
        logic [11:0] want;
        logic [27:0] codes;
        capture(384, 1'b1, 40, 16'h3456, 254, 16'h0C0D);
        for (int t = 0; t < 384; t++) begin
            codes = (t < 128) ? C_12AF : (t < 256) ? C_3456 : C_0C0D;
            got   = {an_s[t], seg_s[t], dp_s[t]};
            want  = exp_word(t, 4'hF, codes, 4'h0, 15);
            vecs++;
            if (got !== want) begin
                errs++;
                $display("FAIL load_timing t=%0d: got %h want %h", t, got, want);
            end
            vecs++;
            if (fd_s[t] !== ((t % 128) == 127)) begin
                errs++;
                $display("FAIL load_fd t=%0d: got %b want %b", t, fd_s[t], (t % 128) == 127);
            end
        end
    endtask

    task automatic test_dp_enable();
        logic [11:0] got;
        logic [11:0] want;
        value    = 16'h12AF;
        dp_in    = 4'b0100;
        digit_en = 4'b1011;
        pulse_load();
        capture(128, 1'b1, -1, 16'h0, -1, 16'h0);
        for (int t = 0; t < 128; t++) begin
            got  = {an_s[t], seg_s[t], dp_s[t]};
            want = exp_word(t, 4'b1011, C_12AF, 4'b0100, 15);
            vecs++;
            if (got !== want) begin
                errs++;
                $display("FAIL dp_en1011 t=%0d: got %h want %h", t, got, want);
            end
        end
        digit_en = 4'hF;
        pulse_load();
        capture(128, 1'b1, -1, 16'h0, -1, 16'h0);
        for (int t = 0; t < 128; t++) begin
            got  = {an_s[t], seg_s[t], dp_s[t]};
            want = exp_word(t, 4'hF, C_12AF, 4'b0100, 15);
            vecs++;
            if (got !== want) begin
                errs++;
                $display("FAIL dp_en1111 t=%0d: got %h want %h", t, got, want);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [11:0] got;
        logic [11:0] want;
        capture(40, 1'b1, -1, 16'h0, -1, 16'h0);
        vecs++;
        if (an_s[39] !== 4'b1101) begin
            errs++;
            $display("FAIL pre_reset: got an=%b want 1101", an_s[39]);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL async_reset: got an=%b seg=%h dp=%b fd=%b, want 1111/7f/1/0", an, seg, dp, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture(256, 1'b0, 10, 16'h12AF, -1, 16'h0);
        for (int t = 0; t < 256; t++) begin
            got  = {an_s[t], seg_s[t], dp_s[t]};
            want = exp_word(t, (t < 128) ? 4'h0 : 4'hF, C_12AF, 4'b0100, 15);
            vecs++;
            if (got !== want) begin
                errs++;
                $display("FAIL restart t=%0d: got %h want %h", t, got, want);
            end
            vecs++;
            if (fd_s[t] !== ((t % 128) == 127)) begin
                errs++;
                $display("FAIL restart_fd t=%0d: got %b want %b", t, fd_s[t], (t % 128) == 127);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_lz_blank();
        test_brightness();
        test_load_timing();
        test_dp_enable();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
